// File: rtl/robot_seq_pkg.sv
// robot_seq_pkg: shared state encoding, command bit positions and heading constants for the actuator sequencer
package robot_seq_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_DRIVE, ST_ROTATE, ST_BRUSH, ST_ACK, ST_FAULT} seq_state_t;
  localparam int CMD_FRONT = 2;
  localparam int CMD_TURN = 1;
  localparam int CMD_REMOVE = 0;
  localparam logic [2:0] OP_FRONT = 3'(1 << CMD_FRONT);
  localparam logic [2:0] OP_TURN = 3'(1 << CMD_TURN);
  localparam logic [2:0] OP_REMOVE = 3'(1 << CMD_REMOVE);
  localparam logic [1:0] HEAD_N = 2'd0;
  localparam logic [1:0] HEAD_E = 2'd1;
  localparam logic [1:0] HEAD_S = 2'd2;
  localparam logic [1:0] HEAD_W = 2'd3;
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/robot_actuator_sequencer_if.sv
// robot_actuator_sequencer_if: command inputs from the decision FSM and actuator/status outputs
interface robot_actuator_sequencer_if #(parameter int CNT_W = 8);
  logic front, turn, remove;
  logic drive_motor, rotate_motor, brush_motor;
  logic busy, step_done, fault;
  logic [1:0] heading;
  logic [CNT_W-1:0] move_count, trash_count;
  modport master (
    output front, turn, remove,
    input drive_motor, rotate_motor, brush_motor, busy, step_done, fault, heading, move_count, trash_count
  );
  modport slave (
    input front, turn, remove,
    output drive_motor, rotate_motor, brush_motor, busy, step_done, fault, heading, move_count, trash_count
  );
endinterface

// File: rtl/robot_action_timer.sv
// robot_action_timer: loadable down-counter that parks at zero and flags it
module robot_action_timer #(parameter int W = 3) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);
  logic [W-1:0] count;
  assign zero = count == '0;
  always_ff @(posedge clock or negedge reset)
    if (!reset) count <= '0;
    else count <= load ? load_value : zero ? count : count - 1'b1;
endmodule

// File: rtl/robot_actuator_sequencer.sv
// robot_actuator_sequencer: turns level-coded FSM commands into timed actuator pulses with a step_done strobe
module robot_actuator_sequencer
  import robot_seq_pkg::*;
#(
  parameter int FRONT_CYCLES = 8,
  parameter int TURN_CYCLES = 4,
  parameter int REMOVE_CYCLES = 6,
  parameter int CNT_W = 8
) (
  input logic clock,
  input logic reset,
  robot_actuator_sequencer_if.slave bus
);
  localparam int TW = timer_width(FRONT_CYCLES, TURN_CYCLES, REMOVE_CYCLES);
  typedef logic [CNT_W-1:0] cnt_t;
  seq_state_t state;
  logic [2:0] cmd;
  logic load, zero;
  logic [TW-1:0] load_value;
  always_comb begin
    cmd = '0;
    cmd[CMD_FRONT] = bus.front;
    cmd[CMD_TURN] = bus.turn;
    cmd[CMD_REMOVE] = bus.remove;
  end
  assign load = state == ST_IDLE && $onehot(cmd);
  assign load_value = cmd == OP_FRONT ? TW'(FRONT_CYCLES - 1) :
                      cmd == OP_TURN  ? TW'(TURN_CYCLES - 1) : TW'(REMOVE_CYCLES - 1);
  robot_action_timer #(.W(TW)) timer (
    .clock(clock),
    .reset(reset),
    .load(load),
    .load_value(load_value),
    .zero(zero)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= ST_IDLE;
      bus.drive_motor <= 1'b0;
      bus.rotate_motor <= 1'b0;
      bus.brush_motor <= 1'b0;
      bus.busy <= 1'b0;
      bus.step_done <= 1'b0;
      bus.fault <= 1'b0;
      bus.heading <= HEAD_N;
      bus.move_count <= '0;
      bus.trash_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= cmd == OP_FRONT  ? ST_DRIVE :
                   cmd == OP_TURN   ? ST_ROTATE :
                   cmd == OP_REMOVE ? ST_BRUSH :
                   cmd == 3'b000    ? ST_ACK : ST_FAULT;
          bus.drive_motor <= cmd == OP_FRONT;
          bus.rotate_motor <= cmd == OP_TURN;
          bus.brush_motor <= cmd == OP_REMOVE;
          bus.step_done <= cmd == 3'b000;
          bus.fault <= !$onehot0(cmd);
          bus.busy <= 1'b1;
        end
        ST_DRIVE, ST_ROTATE, ST_BRUSH:
          if (zero) begin
            state <= ST_ACK;
            bus.drive_motor <= 1'b0;
            bus.rotate_motor <= 1'b0;
            bus.brush_motor <= 1'b0;
            bus.step_done <= 1'b1;
            if (state == ST_DRIVE && bus.move_count != '1) bus.move_count <= bus.move_count + cnt_t'(1);
            if (state == ST_ROTATE) bus.heading <= bus.heading + 2'd1;
            if (state == ST_BRUSH && bus.trash_count != '1) bus.trash_count <= bus.trash_count + cnt_t'(1);
          end
        ST_ACK: begin
          state <= ST_IDLE;
          bus.step_done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= ST_FAULT;
      endcase
    end
endmodule

// File: tb/tb_robot_actuator_sequencer.sv
// tb_robot_actuator_sequencer: randomized command stream checked by a step_done-driven scoreboard
module tb_robot_actuator_sequencer;
  localparam int FC = 8, TC = 4, RC = 6, CW = 2;
  localparam int SAT = (1 << CW) - 1;
  typedef struct { int hd; int mv; int tr; int d; int r; int b; int bsy; } exp_t;
  logic clock = 1'b0, reset = 1'b0;
  robot_actuator_sequencer_if #(.CNT_W(CW)) bus ();
  robot_actuator_sequencer #(.FRONT_CYCLES(FC), .TURN_CYCLES(TC), .REMOVE_CYCLES(RC), .CNT_W(CW)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  int checks = 0, passes = 0;
  int m_hd = 0, m_mv = 0, m_tr = 0;
  int a_d = 0, a_r = 0, a_b = 0, a_bsy = 0, multi = 0;
  exp_t q[$];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask
  always @(negedge clock) begin
    if (!reset) begin
      a_d = 0; a_r = 0; a_b = 0; a_bsy = 0;
    end else begin
      a_d += int'(bus.drive_motor);
      a_r += int'(bus.rotate_motor);
      a_b += int'(bus.brush_motor);
      a_bsy += int'(bus.busy);
      if (int'(bus.drive_motor) + int'(bus.rotate_motor) + int'(bus.brush_motor) > 1) multi++;
      if (bus.step_done) begin
        if (q.size() == 0) chk("unexpected_step_done", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("heading", int'(bus.heading), e.hd);
          chk("move_count", int'(bus.move_count), e.mv);
          chk("trash_count", int'(bus.trash_count), e.tr);
          chk("drive_cycles", a_d, e.d);
          chk("rotate_cycles", a_r, e.r);
          chk("brush_cycles", a_b, e.b);
          chk("busy_cycles", a_bsy, e.bsy);
        end
        a_d = 0; a_r = 0; a_b = 0; a_bsy = 0;
      end
    end
  end
  task automatic set_cmd(input logic [2:0] c);
    {bus.front, bus.turn, bus.remove} = c;
  endtask
  task automatic issue(input logic [2:0] c);
    exp_t e;
    bit done = 0;
    if (c == 3'b100) m_mv = m_mv < SAT ? m_mv + 1 : SAT;
    if (c == 3'b010) m_hd = (m_hd + 1) % 4;
    if (c == 3'b001) m_tr = m_tr < SAT ? m_tr + 1 : SAT;
    e.hd = m_hd; e.mv = m_mv; e.tr = m_tr;
    e.d = c == 3'b100 ? FC : 0;
    e.r = c == 3'b010 ? TC : 0;
    e.b = c == 3'b001 ? RC : 0;
    e.bsy = e.d + e.r + e.b + 1;
    q.push_back(e);
    set_cmd(c);
    @(posedge clock);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      done = bus.step_done;
      set_cmd(3'($urandom));
    end
    if (!done) chk("step_done_timeout", 0, 1);
    @(negedge clock);
  endtask
  function automatic logic [2:0] rand_cmd();
    int k;
    k = $urandom_range(0, 3);
    return k == 0 ? 3'b000 : k == 1 ? 3'b100 : k == 2 ? 3'b010 : 3'b001;
  endfunction
  initial begin
    int sd;
    set_cmd(3'b000);
    repeat (3) @(negedge clock);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_motors", int'({bus.drive_motor, bus.rotate_motor, bus.brush_motor}), 0);
    chk("rst_fault", int'(bus.fault), 0);
    chk("rst_counts", int'({bus.heading, bus.move_count, bus.trash_count, bus.step_done}), 0);
    reset = 1'b1;
    issue(3'b100);
    repeat (4) issue(3'b010);
    repeat (5) issue(3'b001);
    issue(3'b000);
    repeat (60) issue(rand_cmd());
    set_cmd(3'b110);
    @(negedge clock);
    chk("fault_flag", int'(bus.fault), 1);
    chk("fault_busy", int'(bus.busy), 1);
    chk("fault_motors", int'({bus.drive_motor, bus.rotate_motor, bus.brush_motor}), 0);
    sd = 0;
    repeat (50) begin
      @(negedge clock);
      set_cmd(3'($urandom));
      sd += int'(bus.step_done);
    end
    chk("fault_no_step_done", sd, 0);
    chk("fault_sticky", int'(bus.fault), 1);
    reset = 1'b0;
    #1;
    m_hd = 0; m_mv = 0; m_tr = 0;
    chk("fault_cleared", int'(bus.fault), 0);
    chk("fault_busy_cleared", int'(bus.busy), 0);
    @(negedge clock);
    reset = 1'b1;
    issue(3'b100);
    set_cmd(3'b100);
    @(posedge clock);
    repeat (3) @(negedge clock);
    chk("mid_drive_motor_on", int'(bus.drive_motor), 1);
    #2 reset = 1'b0;
    #1;
    m_hd = 0; m_mv = 0; m_tr = 0;
    chk("mid_drive_motor_killed", int'(bus.drive_motor), 0);
    chk("mid_drive_move_count", int'(bus.move_count), 0);
    set_cmd(3'b000);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    chk("post_reset_busy", int'(bus.busy), 0);
    issue(3'b100);
    issue(3'b010);
    repeat (10) issue(rand_cmd());
    chk("multi_motor_cycles", multi, 0);
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/robot_actuator_sequencer.md
Name: robot_actuator_sequencer

Overview:
Downstream stage of the pipe-cleaning robot's decision FSM. It takes the FSM's level-coded command outputs (front, turn, remove) and turns each one into a timed actuator pulse: drive motor, rotate motor or trash brush. It returns a one-cycle step_done strobe, which the integration uses as the decision FSM's clock enable, so exactly one decision is made per completed action. It also keeps heading and odometry/trash statistics for the host.

Parameters:
FRONT_CYCLES, 8, cycles drive_motor stays high per front command (>=1)
TURN_CYCLES, 4, cycles rotate_motor stays high per 90-degree turn (>=1)
REMOVE_CYCLES, 6, cycles brush_motor stays high per remove command (>=1)
CNT_W, 8, width of move_count and trash_count (>=1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
front  input  1  command from decision FSM: advance one cell
turn  input  1  command: rotate 90 degrees clockwise
remove  input  1  command: run trash brush
drive_motor  output  1  drive actuator enable
rotate_motor  output  1  rotation actuator enable
brush_motor  output  1  brush actuator enable
busy  output  1  high whenever state != IDLE
step_done  output  1  one-cycle strobe: action finished, FSM may advance
fault  output  1  sticky: illegal command combination seen
heading  output  2  0=N,1=E,2=S,3=W; increments mod 4 per completed turn
move_count  output  CNT_W  completed front moves, saturating
trash_count  output  CNT_W  completed removals, saturating

Behaviour:
- Reset: reset is asynchronous and active-low; clock is clock. While reset=0, all outputs are 0 (motors, busy, step_done, fault, heading, counts), the state is IDLE and the timer is 0. Asserting reset mid-action kills the motors immediately.
- All outputs are registered.
- States: IDLE, DRIVE, ROTATE, BRUSH, ACK, FAULT.
- IDLE samples {front, turn, remove} at each rising edge:
  - 100 -> DRIVE, timer loaded FRONT_CYCLES-1
  - 010 -> ROTATE, timer loaded TURN_CYCLES-1
  - 001 -> BRUSH, timer loaded REMOVE_CYCLES-1
  - 000 (FSM reset/stand-by no-op) -> ACK
  - any 2 or 3 bits set -> FAULT
- DRIVE/ROTATE/BRUSH:
  - Matching motor output is high for every cycle spent in the state: exactly N cycles, starting the cycle after the sampling edge.
  - Timer decrements each cycle. When timer==0 the next state is ACK and the completion side effects are applied at that edge:
    - DRIVE: move_count+1, saturating at 2^CNT_W-1
    - ROTATE: heading+1 mod 4 (3 wraps to 0)
    - BRUSH: trash_count+1, saturating
  - Command inputs are ignored while in an action state.
- ACK: step_done=1 for exactly this one cycle, all motors 0, inputs not sampled (the FSM updates at the end of this cycle). Next state is IDLE.
- Cycle counts: a command cycle is IDLE -> N action cycles -> ACK -> IDLE. A no-op is IDLE -> ACK -> IDLE.
- FAULT: motors 0, fault=1, busy=1, step_done never asserted. Left only by reset.
- At most one motor is high in any cycle (invariant for verification).
- busy=0 only in IDLE.

Decomposition:
- Package robot_seq_pkg:
  - state enum encoding (IDLE, DRIVE, ROTATE, BRUSH, ACK, FAULT)
  - command bit positions (CMD_FRONT=2, CMD_TURN=1, CMD_REMOVE=0)
  - heading constants N/E/S/W
- One natural sub-module: robot_action_timer, a loadable down-counter.
  - Inputs: load, load_value.
  - Output: zero flag.
  - Width is $clog2 of the largest *_CYCLES, minimum 1.

Test Plan:
1. Reset release, front=1 held with FRONT_CYCLES=8 -> drive_motor high exactly 8 cycles starting 1 cycle after the sample; step_done 1 cycle later; move_count=1; busy high for 9 cycles.
2. Four consecutive turn commands with TURN_CYCLES=4 -> heading 1,2,3,0 (wrap); rotate_motor 4 cycles each; four step_done strobes.
3. front=turn=1 in IDLE -> next cycle fault=1, busy=1, all motors 0; no step_done for 50 cycles; reset clears fault and returns to IDLE.
4. reset pulsed low during cycle 3 of DRIVE -> drive_motor drops asynchronously; move_count stays 0; after release, IDLE with busy=0.
5. CNT_W=2, five remove commands -> trash_count 1,2,3,3,3 (saturates); brush_motor REMOVE_CYCLES cycles each.
6. Inputs 000 in IDLE -> step_done one cycle after the sample with no motor activity. Separately, toggle turn/remove while in DRIVE -> ignored; only drive_motor active; heading and trash_count unchanged.
